// File: rtl/sevenseg_monitor_pkg.sv
// rtl/sevenseg_monitor_pkg.sv - shared glyph table, code constants and monitor state type
package sevenseg_monitor_pkg;

  // Variant digit 4 lights segment a as well; driver and monitor both apply this
  localparam logic [6:0] GLYPH_MASK = 7'b1000000;

  localparam logic [3:0] CODE_E     = 4'hC;
  localparam logic [3:0] CODE_R     = 4'hD;
  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [3:0] CODE_BAD   = 4'hF;

  // Active-high patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] PAT_0     = 7'b1111110;
  localparam logic [6:0] PAT_1     = 7'b0110000;
  localparam logic [6:0] PAT_2     = 7'b1101101;
  localparam logic [6:0] PAT_3     = 7'b1111001;
  localparam logic [6:0] PAT_4     = 7'b0110011;
  localparam logic [6:0] PAT_5     = 7'b1011011;
  localparam logic [6:0] PAT_6     = 7'b1011111;
  localparam logic [6:0] PAT_7     = 7'b1110000;
  localparam logic [6:0] PAT_8     = 7'b1111111;
  localparam logic [6:0] PAT_9     = 7'b1111011;
  localparam logic [6:0] PAT_E     = 7'b1001111;
  localparam logic [6:0] PAT_R     = 7'b0000101;
  localparam logic [6:0] PAT_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } mon_state_e;

endpackage

// File: rtl/sevenseg_monitor_decode.sv
// rtl/sevenseg_monitor_decode.sv - seg_pattern_decode: active-high segment pattern to display code
module seg_pattern_decode
  import sevenseg_monitor_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_code,
  output logic       o_err
);

  always_comb begin
    o_code = CODE_BAD;
    // The masked 4 is checked ahead of the table so it can never alias another glyph
    if (i_pat == (PAT_4 ^ GLYPH_MASK)) begin
      o_code = 4'd4;
    end else begin
      case (i_pat)
        PAT_0:     o_code = 4'd0;
        PAT_1:     o_code = 4'd1;
        PAT_2:     o_code = 4'd2;
        PAT_3:     o_code = 4'd3;
        PAT_4:     o_code = 4'd4;
        PAT_5:     o_code = 4'd5;
        PAT_6:     o_code = 4'd6;
        PAT_7:     o_code = 4'd7;
        PAT_8:     o_code = 4'd8;
        PAT_9:     o_code = 4'd9;
        PAT_E:     o_code = CODE_E;
        PAT_R:     o_code = CODE_R;
        PAT_BLANK: o_code = CODE_BLANK;
        default:   o_code = CODE_BAD;
      endcase
    end
    o_err = (o_code == CODE_BAD);
  end

endmodule

// File: rtl/sevenseg_monitor.sv
// rtl/sevenseg_monitor.sv - segment bus read-back with stability filter; SEVENSEG_MON_CHECK_EN adds mismatch counting
module sevenseg_monitor
  import sevenseg_monitor_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [6:0]       seg_in,
  input  logic [3:0]       expect_code,
  input  logic             expect_valid,
  input  logic             clr_cnt,
  output logic [3:0]       code_out,
  output logic             code_valid,
  output logic             code_err,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  mon_state_e r_state, w_next_state;
  logic [6:0] r_last_pat;
  logic [3:0] r_stab_cnt;
  logic [3:0] r_code;
  logic       r_valid;
  logic       r_err;
  logic       w_restart, w_inc, w_report, w_same;
  logic [6:0] w_pat;
  logic [3:0] w_dec_code;
  logic       w_dec_err;

  assign w_pat  = ~seg_in;
  assign w_same = (seg_in == r_last_pat);

  seg_pattern_decode u_decode (
    .i_pat  (w_pat),
    .o_code (w_dec_code),
    .o_err  (w_dec_err)
  );

  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_inc        = 1'b0;
    w_report     = 1'b0;
    if (sample_en) begin
      case (r_state)
        ST_IDLE:   w_restart = 1'b1;
        ST_SETTLE: if (w_same) w_inc = 1'b1; else w_restart = 1'b1;
        ST_LOCKED: if (!w_same) w_restart = 1'b1;
        default:   w_restart = 1'b1;
      endcase
      if (w_restart) begin
        w_report     = (STABLE_N == 4'd1);
        w_next_state = w_report ? ST_LOCKED : ST_SETTLE;
      end else if (w_inc && ((r_stab_cnt + 4'd1) == STABLE_N)) begin
        w_report     = 1'b1;
        w_next_state = ST_LOCKED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_pat <= 7'h7F;
      r_stab_cnt <= 4'd0;
      r_code     <= CODE_BLANK;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= w_report;
      if (w_restart) begin
        r_last_pat <= seg_in;
        r_stab_cnt <= 4'd1;
      end else if (w_inc) begin
        r_stab_cnt <= r_stab_cnt + 4'd1;
      end
      if (w_report) begin
        r_code <= w_dec_code;
        r_err  <= w_dec_err;
      end
    end
  end

  assign code_out   = r_code;
  assign code_err   = r_err;
  assign code_valid = r_valid;

`ifdef SEVENSEG_MON_CHECK_EN
  logic             r_mismatch;
  logic [CNT_W-1:0] r_mis_cnt;
  logic             w_mis;

  // An illegal pattern decodes to CODE_BAD, but it must count even if CODE_BAD was expected
  assign w_mis = w_report && expect_valid && (w_dec_err || (w_dec_code != expect_code));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= 1'b0;
      r_mis_cnt  <= '0;
    end else begin
      r_mismatch <= w_mis;
      if (clr_cnt)
        r_mis_cnt <= '0;
      else if (w_mis && !(&r_mis_cnt))
        r_mis_cnt <= r_mis_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign mismatch     = r_mismatch;
  assign mismatch_cnt = r_mis_cnt;
`else
  logic w_unused_check;
  assign w_unused_check = ^{expect_code, expect_valid, clr_cnt};
  assign mismatch       = 1'b0;
  assign mismatch_cnt   = '0;
`endif

endmodule

// File: tb/tb_sevenseg_monitor.sv
// tb/tb_sevenseg_monitor.sv - scoreboard bench for sevenseg_monitor (mismatch expectations follow SEVENSEG_MON_CHECK_EN)
module tb_sevenseg_monitor;
  import sevenseg_monitor_pkg::*;

  localparam int S = 4;
`ifdef SEVENSEG_MON_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic [3:0] expect_code = 4'h0;
  logic       expect_valid = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [3:0] code_out;
  logic       code_valid, code_err, mismatch;
  logic [7:0] mismatch_cnt;

  sevenseg_monitor #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .seg_in(seg_in),
    .expect_code(expect_code), .expect_valid(expect_valid), .clr_cnt(clr_cnt),
    .code_out(code_out), .code_valid(code_valid), .code_err(code_err),
    .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       err;
    logic       mis;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int n_pulse = 0;
  int n_exp = 0;

  // reference model state
  bit         m_idle = 1'b1;
  bit         m_locked = 1'b0;
  logic [6:0] m_last = 7'h7F;
  int         m_cnt = 0;
  logic [7:0] m_mis_cnt = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (code_valid === 1'b1) begin
      n_pulse++;
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("code_out", 32'(code_out), 32'(e.code));
        chk("code_err", 32'(code_err), 32'(e.err));
        chk("mismatch", 32'(mismatch), 32'(e.mis));
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e.cnt));
      end
    end else if (!rst) begin
      chk("mismatch_idle", 32'(mismatch), 32'd0);
    end
  end

  task automatic strobe(input logic [6:0] seg, input logic [3:0] ec, input logic ev,
                        input logic clr, input logic [3:0] exp_code);
    bit   rep;
    logic mis;
    exp_t e;
    @(posedge clk);
    #1;
    sample_en    = 1'b1;
    seg_in       = seg;
    expect_code  = ec;
    expect_valid = ev;
    clr_cnt      = clr;
    rep = 1'b0;
    if (m_idle || seg != m_last) begin
      m_idle = 1'b0;
      m_last = seg;
      m_cnt  = 1;
      rep    = (S == 1);
      m_locked = rep;
    end else if (!m_locked) begin
      m_cnt++;
      if (m_cnt == S) begin
        rep = 1'b1;
        m_locked = 1'b1;
      end
    end
    mis = CHK && rep && ev && ((exp_code == CODE_BAD) || (exp_code != ec));
    if (CHK && clr) m_mis_cnt = 8'd0;
    else if (mis && m_mis_cnt != 8'hFF) m_mis_cnt = m_mis_cnt + 8'd1;
    if (rep) begin
      e.code = exp_code;
      e.err  = (exp_code == CODE_BAD);
      e.mis  = mis;
      e.cnt  = m_mis_cnt;
      q.push_back(e);
      n_exp++;
    end
  endtask

  task automatic hold(input logic [6:0] seg, input int n, input logic [3:0] ec,
                      input logic ev, input logic clr, input logic [3:0] exp_code);
    for (int i = 0; i < n; i++) strobe(seg, ec, ev, clr, exp_code);
  endtask

  task automatic idle_and_check(input string tag);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    expect_valid = 1'b0;
    clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_pulses"}, 32'(n_pulse), 32'(n_exp));
    chk({tag, "_queue"}, 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_code_out"}, 32'(code_out), 32'(CODE_BLANK));
    chk({tag, "_code_valid"}, 32'(code_valid), 32'd0);
    chk({tag, "_code_err"}, 32'(code_err), 32'd0);
    chk({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    chk({tag, "_cnt"}, 32'(mismatch_cnt), 32'd0);
  endtask

  initial begin
    logic [6:0] masked4;
    masked4 = ~(PAT_4 ^ GLYPH_MASK);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // stable digit 1
    hold(7'h4F, 4, 4'd1, 1'b1, 1'b0, 4'd1);
    idle_and_check("stable");
    chk("stable_cnt", 32'(mismatch_cnt), 32'd0);

    // glitch rejection
    hold(7'h4F, 3, 4'd1, 1'b1, 1'b0, 4'd1);
    hold(7'h30, 1, 4'd1, 1'b1, 1'b0, CODE_E);
    hold(7'h4F, 3, 4'd1, 1'b1, 1'b0, 4'd1);
    idle_and_check("glitch_pre");
    hold(7'h4F, 1, 4'd1, 1'b1, 1'b0, 4'd1);
    idle_and_check("glitch");
    chk("glitch_code", 32'(code_out), 32'd1);

    // masked 4 and letters
    hold(masked4, 4, 4'd0, 1'b0, 1'b0, 4'd4);
    hold(7'h30,   4, 4'd0, 1'b0, 1'b0, CODE_E);
    hold(7'h7A,   4, 4'd0, 1'b0, 1'b0, CODE_R);
    hold(7'h7F,   4, 4'd0, 1'b0, 1'b0, CODE_BLANK);
    idle_and_check("glyphs");
    chk("glyphs_hold_code", 32'(code_out), 32'(CODE_BLANK));

    // illegal pattern
    hold(7'h7E, 4, 4'd3, 1'b1, 1'b0, CODE_BAD);
    idle_and_check("illegal");
    chk("illegal_err_level", 32'(code_err), 32'd1);
    chk("illegal_cnt", 32'(mismatch_cnt), CHK ? 32'd1 : 32'd0);

    // saturation then coincident clear
    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) hold(7'h4F, 4, 4'd3, 1'b1, 1'b0, 4'd1);
      else            hold(7'h30, 4, 4'd3, 1'b1, 1'b0, CODE_E);
    end
    idle_and_check("saturate");
    chk("saturate_cnt", 32'(mismatch_cnt), CHK ? 32'd255 : 32'd0);
    hold(7'h4F, 3, 4'd3, 1'b1, 1'b0, 4'd1);
    hold(7'h4F, 1, 4'd3, 1'b1, 1'b1, 4'd1);
    idle_and_check("clear");
    chk("clear_cnt", 32'(mismatch_cnt), 32'd0);
    hold(7'h30, 4, 4'd0, 1'b0, 1'b0, CODE_E);
    idle_and_check("post_clear");

    // reset mid-settle
    hold(7'h4F, 3, 4'd1, 1'b1, 1'b0, 4'd1);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("in_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    m_idle = 1'b1;
    m_locked = 1'b0;
    m_last = 7'h7F;
    m_cnt = 0;
    m_mis_cnt = 8'd0;
    hold(7'h4F, 3, 4'd1, 1'b1, 1'b0, 4'd1);
    idle_and_check("mid_settle");
    check_reset_vals("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/sevenseg_monitor.md
# sevenseg_monitor

Read-back monitor for the seven-segment display path. It samples the active-low segment bus that drives the display and waits for the pattern to hold stable over a configurable number of sample strobes. It then decodes the pattern back to the 4-bit display code, reversing the output polarity and the `GLYPH_MASK` applied to digit 4. Used for display self-test: the decoded code is compared against the code the controller intended to show, and mismatches are counted.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is reported. Legal range is 1..15.
- `CNT_W`, default 8: width of the mismatch counter.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `sample_en` input 1: sample strobe; `seg_in` is evaluated only on cycles where this is high.
- `seg_in` input 7: segment bus {a..g}, active-low.
- `expect_code` input 4: code the controller intends to display.
- `expect_valid` input 1: qualifies `expect_code`; sampled in the cycle the decode completes.
- `clr_cnt` input 1: synchronous clear of `mismatch_cnt`.
- `code_out` output 4: last reported decoded code.
- `code_valid` output 1: one-cycle pulse when a newly stable pattern is reported.
- `code_err` output 1: level; the last reported pattern is not a legal glyph.
- `mismatch` output 1: one-cycle pulse, coincident with `code_valid`.
- `mismatch_cnt` output `CNT_W`: saturating count of mismatches.

## Operation
- Decode: `pat = ~seg_in`.
  - `pat == 7'b0110011 ^ GLYPH_MASK` gives 4. This check has priority over all other matches.
  - Otherwise the standard table applies: 0–9 map to their usual patterns, `1001111` gives `4'hC` (E), `0000101` gives `4'hD` (r), and `0000000` gives `4'hE` (blank).
  - Any other pattern gives `code_out = 4'hF` and `code_err = 1`.
- State machine, with states IDLE, SETTLE and LOCKED, register `last_pat` (7 bits) and counter `stab_cnt` (4 bits):
  - IDLE → SETTLE on the first `sample_en`: `last_pat <= seg_in`, `stab_cnt <= 1`.
  - SETTLE, `sample_en`, `seg_in == last_pat`: `stab_cnt` increments. When the new count equals `STABLE_CYCLES`, go to LOCKED and report.
  - SETTLE or LOCKED, `sample_en`, `seg_in != last_pat`: `last_pat <= seg_in`, `stab_cnt <= 1`, go to SETTLE.
  - LOCKED, `sample_en`, same pattern: no action and no further pulses.
  - If `STABLE_CYCLES == 1`, a changed or first sample reports immediately and the state goes straight to LOCKED.
  - Cycles without `sample_en` change no state.
- Report:
  - `code_out` and `code_err` are updated and held until the next report.
  - `code_valid` pulses for one cycle.
- Mismatch:
  - Applies when `expect_valid` is high in the report cycle and `decoded != expect_code`. An error pattern always counts as a mismatch.
  - On a mismatch, `mismatch` pulses and `mismatch_cnt` increments, saturating at all-ones.
- `clr_cnt` sets `mismatch_cnt` to 0. If it coincides with an increment, the clear wins.

## Timing
- Reset values: state IDLE, `last_pat = 7'h7F`, `stab_cnt = 0`, `code_out = 4'hE`, and `code_valid`, `code_err`, `mismatch` and `mismatch_cnt` all 0.
- Latency: `code_valid` is high in the cycle immediately following the clock edge that captured the `STABLE_CYCLES`-th identical sample. All outputs are registered, and `code_out`, `code_err` and `mismatch` are valid in that same cycle.
- `rst` asserted mid-settle abandons the count. No pulse is emitted during or after reset until a full stable run has been seen.
- If a new sample differs on the same edge that would have completed a run, there is no report and the count restarts at 1.

## Configuration
- `SEVENSEG_MON_CHECK_EN` defined: mismatch comparison, `mismatch` and `mismatch_cnt` are implemented as above.
- `SEVENSEG_MON_CHECK_EN` undefined:
  - `mismatch` and `mismatch_cnt` are tied to 0.
  - `expect_code`, `expect_valid` and `clr_cnt` are ignored.
  - Decode and report behaviour is unchanged.

## Structure
- The shared team params header holds:
  - `GLYPH_MASK`;
  - code constants `CODE_E = 4'hC`, `CODE_R = 4'hD`, `CODE_BLANK = 4'hE`, `CODE_BAD = 4'hF`;
  - the 7-bit glyph pattern constants, so that driver and monitor share one table.
- One combinational sub-module, `seg_pattern_decode`: 7-bit active-high pattern in, 4-bit code plus error flag out, applying the mask-aware priority above.
- The FSM, stability counter and mismatch logic live in `sevenseg_monitor`.

## Test plan
- Stable digit:
  - Stimulus: `seg_in = 7'h4F` (digit 1) on 4 consecutive strobes, with `expect_code = 1` and `expect_valid = 1`.
  - Response: one `code_valid` pulse, `code_out = 1`, no mismatch, `mismatch_cnt = 0`.
- Glitch rejection:
  - Stimulus: `7'h4F` ×3, then `7'h30` ×1, then `7'h4F` ×4.
  - Response: exactly one pulse, after the 8th strobe, with `code_out = 1`.
- Masked 4 and letters:
  - Stimulus: drive `~(7'b0110011 ^ GLYPH_MASK)`, then `7'h30`, then `7'h7A`, then `7'h7F`, each held for 4 strobes.
  - Response: `code_out` = 4, C, D, E in turn, with `code_err = 0`.
- Illegal pattern:
  - Stimulus: `7'h7E` held for 4 strobes with `expect_code = 3` and `expect_valid = 1`.
  - Response: `code_out = F`, `code_err = 1`, `mismatch` pulses, `mismatch_cnt = 1`.
- Counter saturation and clear:
  - Stimulus: force 260 mismatches with `CNT_W = 8`, then assert `clr_cnt` coincident with a mismatch.
  - Response: the count holds at 255, then reads 0 after the clear.
- Reset mid-settle:
  - Stimulus: 3 strobes of `7'h4F`, pulse `rst`, then 3 more strobes.
  - Response: no `code_valid`; outputs at their reset values.
